// File: rtl/nonce_dispatcher_if.sv
// Handshake and broadcast bundle between the nonce dispatcher and its
// consumer / SHA core bank. Widths follow the dispatcher parameters.
interface nonce_dispatcher_if #(
    parameter int NCORE   = 4,
    parameter int ROUNDS  = 64,
    parameter int NONCE_W = 32
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    // Job control and core/consumer feedback
    logic               job_start;
    logic               job_abort;
    logic [NCORE-1:0]   core_found;
    logic               found_ack;

    // Dispatcher outputs
    logic [CW-1:0]      cycle;
    logic               hash_start;
    logic [NONCE_W-1:0] nonce_base;
    logic               busy;
    logic               found_valid;
    logic [NONCE_W-1:0] found_nonce;
    logic [IW-1:0]      found_core;
    logic               exhausted;

    // Dispatcher side
    modport slave (
        input  job_start, job_abort, core_found, found_ack,
        output cycle, hash_start, nonce_base, busy,
               found_valid, found_nonce, found_core, exhausted
    );

    // Job owner / consumer side
    modport master (
        output job_start, job_abort, core_found, found_ack,
        input  cycle, hash_start, nonce_base, busy,
               found_valid, found_nonce, found_core, exhausted
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// Nonce search sequencer for a bank of NCORE SHA-256 cores. Core i hashes
// nonce_base + i*RANGE, so each core owns one equal slice of the nonce space.
// The dispatcher steps nonce_base once per hash, arbitrates hits (lowest core
// index wins), reports the winner over a valid/ack handshake and flags
// exhaustion when every slice has been searched without a hit.
module nonce_dispatcher #(
    parameter int NCORE   = 4,
    parameter int ROUNDS  = 64,
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    nonce_dispatcher_if.slave  bus
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    // Slice size; the highest core's offset plus the highest base always
    // stays below 2^NONCE_W, so found_nonce never overflows.
    localparam logic [NONCE_W-1:0] ALL_ONES   = {NONCE_W{1'b1}};
    localparam logic [NONCE_W-1:0] RANGE      = ALL_ONES / NONCE_W'(NCORE);
    localparam logic [NONCE_W-1:0] LAST_BASE  = RANGE - NONCE_W'(1);
    localparam logic [CW-1:0]      LAST_CYCLE = CW'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state_q,       state_d;
    logic [CW-1:0]      cycle_q,       cycle_d;
    logic [NONCE_W-1:0] nonce_base_q,  nonce_base_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
    logic [IW-1:0]      found_core_q,  found_core_d;

    logic [IW-1:0]      hit_idx;
    logic [NONCE_W-1:0] hit_offset;
    logic               any_hit;

    // Lowest-index priority encoder over the core hit flags
    always_comb begin
        hit_idx = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (bus.core_found[i]) begin
                hit_idx = IW'(i);
            end
        end
        any_hit    = |bus.core_found;
        hit_offset = NONCE_W'(hit_idx) * RANGE;
    end

    // Next-state logic; abort overrides everything else in the same clock
    always_comb begin
        state_d       = state_q;
        cycle_d       = cycle_q;
        nonce_base_d  = nonce_base_q;
        found_nonce_d = found_nonce_q;
        found_core_d  = found_core_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.job_start) begin
                    state_d      = S_RUN;
                    cycle_d      = '0;
                    nonce_base_d = '0;
                end
            end
            S_RUN: begin
                if (cycle_q == LAST_CYCLE) begin
                    cycle_d = '0;
                    if (any_hit) begin
                        found_core_d  = hit_idx;
                        found_nonce_d = nonce_base_q + hit_offset;
                        state_d       = S_REPORT;
                    end else if (nonce_base_q == LAST_BASE) begin
                        state_d = S_DONE;
                    end else begin
                        nonce_base_d = nonce_base_q + NONCE_W'(1);
                    end
                end else begin
                    cycle_d = cycle_q + CW'(1);
                end
            end
            S_REPORT: begin
                // found_valid is decoded from this state, so an ack seen
                // on the entering clock never reaches this branch
                if (bus.found_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.job_abort) begin
            state_d      = S_IDLE;
            cycle_d      = '0;
            nonce_base_d = '0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            cycle_q       <= '0;
            nonce_base_q  <= '0;
            found_nonce_q <= '0;
            found_core_q  <= '0;
        end else begin
            state_q       <= state_d;
            cycle_q       <= cycle_d;
            nonce_base_q  <= nonce_base_d;
            found_nonce_q <= found_nonce_d;
            found_core_q  <= found_core_d;
        end
    end

    // Outputs come straight from registers or decodes of the state register
    assign bus.cycle       = cycle_q;
    assign bus.nonce_base  = nonce_base_q;
    assign bus.found_nonce = found_nonce_q;
    assign bus.found_core  = found_core_q;
    assign bus.hash_start  = (state_q == S_RUN) && (cycle_q == '0);
    assign bus.busy        = (state_q == S_RUN) || (state_q == S_REPORT);
    assign bus.found_valid = (state_q == S_REPORT);
    assign bus.exhausted   = (state_q == S_DONE);
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: a full-size instance (4 cores,
// 64 rounds, 32-bit nonce) and a small one (4 cores, 4 rounds, 8-bit nonce,
// RANGE = 63) for the exhaustion path.
module tb_nonce_dispatcher;
    logic clk;
    logic n_rst;

    int n_checks;
    int n_pass;

    nonce_dispatcher_if #(.NCORE(4), .ROUNDS(64), .NONCE_W(32)) ifa ();
    nonce_dispatcher_if #(.NCORE(4), .ROUNDS(4),  .NONCE_W(8))  ifb ();

    nonce_dispatcher #(.NCORE(4), .ROUNDS(64), .NONCE_W(32)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifa)
    );

    nonce_dispatcher #(.NCORE(4), .ROUNDS(4), .NONCE_W(8)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, prints one line per check
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-24s got %0d", tag, got);
        end else begin
            $display("FAIL %-24s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_a();
        ifa.job_start = 1'b1;
        tick(1);
        ifa.job_start = 1'b0;
    endtask

    task automatic start_b();
        ifb.job_start = 1'b1;
        tick(1);
        ifb.job_start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_rst    = 1'b0;
        ifa.job_start = 1'b0; ifa.job_abort = 1'b0; ifa.core_found = '0; ifa.found_ack = 1'b0;
        ifb.job_start = 1'b0; ifb.job_abort = 1'b0; ifb.core_found = '0; ifb.found_ack = 1'b0;

        tick(2);
        n_rst = 1'b1;
        tick(1);

        // 1. Asynchronous reset mid-RUN, then idle
        start_a();
        tick(5);
        check("pre_reset_busy", 64'(ifa.busy), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rst_busy",        64'(ifa.busy),        64'd0);
        check("rst_cycle",       64'(ifa.cycle),       64'd0);
        check("rst_hash_start",  64'(ifa.hash_start),  64'd0);
        check("rst_found_valid", 64'(ifa.found_valid), 64'd0);
        check("rst_exhausted",   64'(ifa.exhausted),   64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick(5);
        check("idle_busy",       64'(ifa.busy),        64'd0);
        check("idle_cycle",      64'(ifa.cycle),       64'd0);
        check("idle_nonce_base", 64'(ifa.nonce_base),  64'd0);

        // 2. Sweep with no hits
        start_a();
        check("sw_hash_start0",  64'(ifa.hash_start),  64'd1);
        check("sw_base0",        64'(ifa.nonce_base),  64'd0);
        check("sw_busy",         64'(ifa.busy),        64'd1);
        tick(1);
        check("sw_cycle1",       64'(ifa.cycle),       64'd1);
        check("sw_hash_start1",  64'(ifa.hash_start),  64'd0);
        tick(62);
        check("sw_cycle63",      64'(ifa.cycle),       64'd63);
        tick(1);
        check("sw_cycle_wrap",   64'(ifa.cycle),       64'd0);
        check("sw_base1",        64'(ifa.nonce_base),  64'd1);
        check("sw_hash_start64", 64'(ifa.hash_start),  64'd1);
        tick(64);
        check("sw_base2",        64'(ifa.nonce_base),  64'd2);
        check("sw_hash_start128",64'(ifa.hash_start),  64'd1);

        // 4. Hit at the wrong cycle is ignored
        tick(10);
        check("mt_cycle10",      64'(ifa.cycle),       64'd10);
        ifa.core_found = 4'b0001;
        tick(1);
        ifa.core_found = 4'b0000;
        check("mt_no_valid",     64'(ifa.found_valid), 64'd0);
        tick(52);
        check("mt_cycle63",      64'(ifa.cycle),       64'd63);
        tick(1);
        check("mt_base3",        64'(ifa.nonce_base),  64'd3);
        check("mt_still_busy",   64'(ifa.busy),        64'd1);

        // 3. Arbitration at base 5; ack on the entering clock is ignored
        tick(128 + 63);
        check("fa_base5",        64'(ifa.nonce_base),  64'd5);
        check("fa_cycle63",      64'(ifa.cycle),       64'd63);
        ifa.core_found = 4'b0110;
        ifa.found_ack  = 1'b1;
        tick(1);
        ifa.core_found = 4'b0000;
        ifa.found_ack  = 1'b0;
        check("fa_valid",        64'(ifa.found_valid), 64'd1);
        check("fa_core",         64'(ifa.found_core),  64'd1);
        check("fa_nonce",        64'(ifa.found_nonce), 64'd1073741828);
        check("fa_busy",         64'(ifa.busy),        64'd1);
        tick(3);
        check("fa_hold_valid",   64'(ifa.found_valid), 64'd1);
        check("fa_hold_nonce",   64'(ifa.found_nonce), 64'd1073741828);
        check("fa_hold_core",    64'(ifa.found_core),  64'd1);
        ifa.found_ack = 1'b1;
        tick(1);
        ifa.found_ack = 1'b0;
        check("fa_ack_valid",    64'(ifa.found_valid), 64'd0);
        check("fa_ack_busy",     64'(ifa.busy),        64'd0);

        // 6a. Abort beats a simultaneous hit
        start_a();
        tick(63);
        check("ab_cycle63",      64'(ifa.cycle),       64'd63);
        ifa.core_found = 4'b1000;
        ifa.job_abort  = 1'b1;
        tick(1);
        ifa.core_found = 4'b0000;
        ifa.job_abort  = 1'b0;
        check("ab_valid",        64'(ifa.found_valid), 64'd0);
        check("ab_busy",         64'(ifa.busy),        64'd0);
        check("ab_cycle",        64'(ifa.cycle),       64'd0);

        // 6b. Reset during REPORT clears found_valid immediately
        start_a();
        tick(63);
        ifa.core_found = 4'b1001;
        tick(1);
        ifa.core_found = 4'b0000;
        check("rr_valid",        64'(ifa.found_valid), 64'd1);
        check("rr_core",         64'(ifa.found_core),  64'd0);
        check("rr_nonce",        64'(ifa.found_nonce), 64'd0);
        #2 n_rst = 1'b0;
        #1;
        check("rr_rst_valid",    64'(ifa.found_valid), 64'd0);
        check("rr_rst_busy",     64'(ifa.busy),        64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick(1);

        // 5. Exhaustion on the small instance (RANGE = 63, 4 rounds/hash)
        start_b();
        check("ex_busy",         64'(ifb.busy),        64'd1);
        check("ex_base0",        64'(ifb.nonce_base),  64'd0);
        tick(251);
        check("ex_last_base",    64'(ifb.nonce_base),  64'd62);
        check("ex_last_cycle",   64'(ifb.cycle),       64'd3);
        check("ex_not_yet",      64'(ifb.exhausted),   64'd0);
        tick(1);
        check("ex_exhausted",    64'(ifb.exhausted),   64'd1);
        check("ex_idle_busy",    64'(ifb.busy),        64'd0);
        check("ex_base_held",    64'(ifb.nonce_base),  64'd62);
        tick(3);
        check("ex_exh_held",     64'(ifb.exhausted),   64'd1);
        start_b();
        check("ex_restart_exh",  64'(ifb.exhausted),   64'd0);
        check("ex_restart_base", 64'(ifb.nonce_base),  64'd0);
        check("ex_restart_hs",   64'(ifb.hash_start),  64'd1);
        ifb.job_abort = 1'b1;
        tick(1);
        ifb.job_abort = 1'b0;
        check("ex_abort_busy",   64'(ifb.busy),        64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Sequences the nonce search for a bank of NCORE parallel SHA-256 cores.
- Generates the per-hash round counter (cycle) and the shared nonce base.
- Core i hashes nonce base + i*RANGE, so the nonce space is split into NCORE equal slices.
- Arbitrates simultaneous "found" reports from the cores, returns the winning nonce through a valid/ack handshake, and flags exhaustion of the nonce space.

Parameters:
- NCORE, 4: number of SHA cores sharing the nonce space; must be >= 1.
- ROUNDS, 64: clocks per hash; cycle counts 0..ROUNDS-1.
- NONCE_W, 32: nonce width; the bench uses 8 for exhaustion tests.

Ports:
- clk, in, 1: system clock, rising edge.
- n_rst, in, 1: asynchronous active-low reset.
- job_start, in, 1: start a new search (pulse).
- job_abort, in, 1: abandon the current job.
- core_found, in, NCORE: per-core hit flag; valid only at cycle==ROUNDS-1.
- found_ack, in, 1: consumer accepted found_nonce.
- cycle, out, CW = max(1, $clog2(ROUNDS)): round index broadcast to the cores.
- hash_start, out, 1: high when state==RUN and cycle==0.
- nonce_base, out, NONCE_W: slice offset shared by all cores.
- busy, out, 1: high in RUN or REPORT.
- found_valid, out, 1: winning nonce is available.
- found_nonce, out, NONCE_W: winning nonce.
- found_core, out, IW = max(1, $clog2(NCORE)): index of the winning core.
- exhausted, out, 1: nonce space searched with no hit.

Behaviour:
- RANGE = (2^NONCE_W - 1) / NCORE, integer division; a localparam.
- Reset (async, n_rst=0): state=IDLE. cycle, nonce_base, found_nonce, found_core = 0. found_valid, exhausted, busy, hash_start = 0. Reset has effect from any state, including mid-RUN and mid-REPORT.
- States: IDLE, RUN, REPORT, DONE. All outputs are registered or decoded from registered state; no combinational path from input to output.
- IDLE, on job_start:
  - Next state RUN; cycle=0, nonce_base=0, exhausted=0.
  - hash_start is high in the first RUN clock.
- RUN:
  - cycle increments by 1 each clock.
  - At cycle==ROUNDS-1, core_found is sampled, with priority in this order:
    1. Any bit set: the lowest set index wins. found_core=idx; found_nonce = nonce_base + idx*RANGE, truncated to NONCE_W; next state REPORT.
    2. No hit and nonce_base==RANGE-1: next state DONE.
    3. Otherwise nonce_base += 1, cycle=0, stay in RUN.
  - core_found at any other cycle value is ignored.
  - job_start while in RUN is ignored.
- REPORT:
  - found_valid=1; found_nonce and found_core are held stable.
  - found_ack sampled high: found_valid=0 on the next clock, next state IDLE.
  - found_ack in the same clock that REPORT is entered has no effect; ack is only honoured while found_valid=1.
- DONE:
  - exhausted=1, held until the next job_start or job_abort.
  - job_start: next state RUN with a clean restart.
- job_abort, in any state:
  - Next state IDLE; cycle and nonce_base cleared; found_valid=0; exhausted=0.
  - Abort takes priority over job_start, core_found and found_ack in the same clock.
- busy=1 exactly in RUN and REPORT.
- Latency:
  - job_start to first hash_start: 1 clock.
  - Sampled hit to found_valid: 1 clock.
  - Hash throughput: one nonce_base value per ROUNDS clocks.
- Wrap-around: nonce_base never wraps; it stops at RANGE-1. found_nonce addition is modulo 2^NONCE_W and cannot overflow, by construction of RANGE.
- NCORE=1: found_core is a constant 0; RANGE = 2^NONCE_W - 1.

Test Plan:
1. Reset: assert n_rst=0 asynchronously mid-clock -> all outputs 0 immediately, state IDLE; release, idle 5 clocks -> outputs remain 0.
2. Sweep (NCORE=4, ROUNDS=64, NONCE_W=32), job_start, no hits:
   - cycle runs 0..63 and wraps; hash_start pulses every 64 clocks.
   - nonce_base is 0, 1, 2 at clocks 1, 65, 129 after start; busy=1.
3. Found arbitration: core_found=4'b0110 at cycle==63 with nonce_base=5 -> found_valid=1, found_core=1, found_nonce=1073741828. Hold ack off 3 clocks -> values stable; ack -> IDLE, busy=0.
4. Mis-timed hit: core_found=4'b0001 only at cycle==10 -> ignored, RUN continues, nonce_base increments normally.
5. Exhaustion (NONCE_W=8, NCORE=4, ROUNDS=4, so RANGE=63): no hits -> DONE after base 62 completes, exhausted=1 held; job_start -> RUN with nonce_base=0, exhausted=0.
6. Abort precedence: job_abort together with a hit at cycle==63 -> IDLE, found_valid stays 0. Separately, n_rst low during REPORT -> found_valid=0 asynchronously.
